// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode slice: icodes, register IDs,
// pipeline bundle layouts and the forwarding priority helper.
package y86_pkg;

    localparam int WORD = 64;
    localparam int D_W  = 2*WORD + 17;
    localparam int E_W  = 3*WORD + 25;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic STAT_AOK = 1'b1;

    // D bundle bit offsets (field LSBs)
    localparam int D_STAT  = 144;
    localparam int D_ICODE = 140;
    localparam int D_IFUN  = 136;
    localparam int D_RA    = 132;
    localparam int D_RB    = 128;
    localparam int D_VALC  = 64;
    localparam int D_VALP  = 0;

    // E bundle bit offsets (field LSBs)
    localparam int E_STAT  = 216;
    localparam int E_ICODE = 212;
    localparam int E_IFUN  = 208;
    localparam int E_VALC  = 144;
    localparam int E_VALA  = 80;
    localparam int E_VALB  = 16;
    localparam int E_DSTE  = 12;
    localparam int E_DSTM  = 8;
    localparam int E_SRCA  = 4;
    localparam int E_SRCB  = 0;

    typedef struct packed {
        logic            stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      ra;
        logic [3:0]      rb;
        logic [WORD-1:0] valc;
        logic [WORD-1:0] valp;
    } d_bundle_t;

    typedef struct packed {
        logic            stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [WORD-1:0] valc;
        logic [WORD-1:0] vala;
        logic [WORD-1:0] valb;
        logic [3:0]      dste;
        logic [3:0]      dstm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } e_bundle_t;

    localparam d_bundle_t D_BUBBLE = '{
        stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
        valc: '0, valp: '0
    };

    localparam e_bundle_t E_BUBBLE = '{
        stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
        dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
    };

    function automatic d_bundle_t unpack_d(input logic [D_W-1:0] v);
        d_bundle_t d;
        d.stat  = v[D_STAT];
        d.icode = v[D_ICODE +: 4];
        d.ifun  = v[D_IFUN  +: 4];
        d.ra    = v[D_RA    +: 4];
        d.rb    = v[D_RB    +: 4];
        d.valc  = v[D_VALC  +: WORD];
        d.valp  = v[D_VALP  +: WORD];
        return d;
    endfunction

    function automatic logic [E_W-1:0] pack_e(input e_bundle_t e);
        logic [E_W-1:0] v;
        v                   = '0;
        v[E_STAT]           = e.stat;
        v[E_ICODE +: 4]     = e.icode;
        v[E_IFUN  +: 4]     = e.ifun;
        v[E_VALC  +: WORD]  = e.valc;
        v[E_VALA  +: WORD]  = e.vala;
        v[E_VALB  +: WORD]  = e.valb;
        v[E_DSTE  +: 4]     = e.dste;
        v[E_DSTM  +: 4]     = e.dstm;
        v[E_SRCA  +: 4]     = e.srca;
        v[E_SRCB  +: 4]     = e.srcb;
        return v;
    endfunction

    // Youngest producer wins; within M and W the memory result outranks the ALU
    // result so a popq into its own stack pointer sees the loaded value.
    function automatic logic [WORD-1:0] fwd_select(
        input logic [3:0]      src,
        input logic [WORD-1:0] rf_val,
        input logic [3:0]      e_dst,  input logic [WORD-1:0] e_val,
        input logic [3:0]      mm_dst, input logic [WORD-1:0] mm_val,
        input logic [3:0]      me_dst, input logic [WORD-1:0] me_val,
        input logic [3:0]      wm_dst, input logic [WORD-1:0] wm_val,
        input logic [3:0]      we_dst, input logic [WORD-1:0] we_val
    );
        if (src == RNONE)  return rf_val;
        if (src == e_dst)  return e_val;
        if (src == mm_dst) return mm_val;
        if (src == me_dst) return me_val;
        if (src == wm_dst) return wm_val;
        if (src == we_dst) return we_val;
        return rf_val;
    endfunction

endpackage

// File: rtl/regfile_15x64.sv
// Fifteen-entry architectural register file: two combinational reads,
// two edge-triggered writes, synchronous clear.
module regfile_15x64 #(
    parameter int XLEN = 64,
    parameter int NREG = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      raddr_a,
    input  logic [3:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic [3:0]      waddr_e,
    input  logic [XLEN-1:0] wdata_e,
    input  logic [3:0]      waddr_m,
    input  logic [XLEN-1:0] wdata_m
);

    logic [NREG-1:0][XLEN-1:0] regs;

    // Port M is checked first so it wins a same-ID collision with port E.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (waddr_m == 4'(i))      regs[i] <= wdata_m;
                else if (waddr_e == 4'(i)) regs[i] <= wdata_e;
            end
        end
    end

    // IDs outside 0..NREG-1 (RNONE) read as zero.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == 4'(i)) rdata_a = regs[i];
            if (raddr_b == 4'(i)) rdata_b = regs[i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode: D pipeline register, register-file read, operand forwarding
// and the E pipeline register handed to execute.
module decode_stage
    import y86_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*XLEN+16:0] f_D,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              E_bubble,
    input  logic [3:0]        e_dstE,
    input  logic [XLEN-1:0]   e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [XLEN-1:0]   M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [XLEN-1:0]   m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [XLEN-1:0]   W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [XLEN-1:0]   W_valM,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3*XLEN+24:0] E
);

    d_bundle_t       d_reg;
    e_bundle_t       e_reg;
    e_bundle_t       e_next;
    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] d_valA;
    logic [XLEN-1:0] d_valB;

    always_ff @(posedge clk) begin
        if (rst)           d_reg <= D_BUBBLE;
        else if (D_stall)  d_reg <= d_reg;
        else if (D_bubble) d_reg <= D_BUBBLE;
        else               d_reg <= unpack_d(f_D);
    end

    // Register selection; unknown icodes (stat already bad) fall through to RNONE.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;

        if (d_reg.icode inside {I_CMOV, I_RMMOV, I_OPQ, I_PUSH}) d_srcA = d_reg.ra;
        else if (d_reg.icode inside {I_RET, I_POP})              d_srcA = RSP;

        if (d_reg.icode inside {I_RMMOV, I_MRMOV, I_OPQ})               d_srcB = d_reg.rb;
        else if (d_reg.icode inside {I_CALL, I_RET, I_PUSH, I_POP})     d_srcB = RSP;

        // cmov always names rB; execute squashes it when the condition fails.
        if (d_reg.icode inside {I_CMOV, I_IRMOV, I_OPQ})                d_dstE = d_reg.rb;
        else if (d_reg.icode inside {I_CALL, I_RET, I_PUSH, I_POP})     d_dstE = RSP;

        if (d_reg.icode inside {I_MRMOV, I_POP}) d_dstM = d_reg.ra;
    end

    regfile_15x64 #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (d_srcA),
        .raddr_b (d_srcB),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .waddr_e (W_dstE),
        .wdata_e (W_valE),
        .waddr_m (W_dstM),
        .wdata_m (W_valM)
    );

    // jXX and call carry the return/fall-through address down the valA lane.
    always_comb begin
        if (d_reg.icode inside {I_JXX, I_CALL})
            d_valA = d_reg.valp;
        else
            d_valA = fwd_select(d_srcA, rf_a, e_dstE, e_valE, M_dstM, m_valM,
                                M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        d_valB = fwd_select(d_srcB, rf_b, e_dstE, e_valE, M_dstM, m_valM,
                            M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    always_comb begin
        e_next       = E_BUBBLE;
        e_next.stat  = d_reg.stat;
        e_next.icode = d_reg.icode;
        e_next.ifun  = d_reg.ifun;
        e_next.valc  = d_reg.valc;
        e_next.vala  = d_valA;
        e_next.valb  = d_valB;
        e_next.dste  = d_dstE;
        e_next.dstm  = d_dstM;
        e_next.srca  = d_srcA;
        e_next.srcb  = d_srcB;
    end

    always_ff @(posedge clk) begin
        if (rst || E_bubble) e_reg <= E_BUBBLE;
        else                 e_reg <= e_next;
    end

    assign E = pack_e(e_reg);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus queues expected E/src values,
// a negedge monitor pops and compares whatever is due that cycle.
module tb_decode_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [144:0] f_D;
    logic         D_stall, D_bubble, E_bubble;
    logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]   d_srcA, d_srcB;
    logic [216:0] E;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .f_D      (f_D),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .e_dstE   (e_dstE),
        .e_valE   (e_valE),
        .M_dstE   (M_dstE),
        .M_valE   (M_valE),
        .M_dstM   (M_dstM),
        .m_valM   (m_valM),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E        (E)
    );

    typedef struct {
        int           due;
        bit           is_src;
        logic [216:0] e;
        logic [7:0]   src;
    } sb_t;

    sb_t   sb_q[$];
    string nm_q[$];
    int    cyc   = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    mi;
    bit    done  = 1'b0;

    logic [144:0] nop_d;
    logic [216:0] bub_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [144:0] mk_d(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] vc, input logic [63:0] vp);
        return {st, ic, fn, ra, rb, vc, vp};
    endfunction

    function automatic logic [216:0] mk_e(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                                          input logic [3:0] de, input logic [3:0] dm,
                                          input logic [3:0] sa, input logic [3:0] sb);
        return {st, ic, fn, vc, va, vb, de, dm, sa, sb};
    endfunction

    // Monitor: compare every entry due this cycle; after the stimulus ends,
    // anything still queued was never reached and counts as a failure.
    always @(negedge clk) begin
        mi = 0;
        while (mi < sb_q.size()) begin
            if (sb_q[mi].due == cyc || done) begin
                n_chk++;
                if (done) begin
                    $display("FAIL %s: never checked (due cycle %0d)", nm_q[mi], sb_q[mi].due);
                end else if (sb_q[mi].is_src) begin
                    if ({d_srcA, d_srcB} === sb_q[mi].src) n_pass++;
                    else $display("FAIL %s: srcA/srcB got %h want %h", nm_q[mi], {d_srcA, d_srcB}, sb_q[mi].src);
                end else begin
                    if (E === sb_q[mi].e) n_pass++;
                    else $display("FAIL %s: E got %h want %h", nm_q[mi], E, sb_q[mi].e);
                end
                sb_q.delete(mi);
                nm_q.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_e(input int due, input logic [216:0] e, input string nm);
        sb_t s;
        s.due = due; s.is_src = 1'b0; s.e = e; s.src = '0;
        sb_q.push_back(s);
        nm_q.push_back(nm);
    endtask

    task automatic exp_s(input int due, input logic [7:0] src, input string nm);
        sb_t s;
        s.due = due; s.is_src = 1'b1; s.e = '0; s.src = src;
        sb_q.push_back(s);
        nm_q.push_back(nm);
    endtask

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
    endtask

    // Drive one fetch bundle; its decoded E appears two edges later.
    task automatic issue(input logic [144:0] fd, input logic [216:0] e, input string nm);
        f_D = fd;
        exp_e(cyc + 2, e, nm);
        step();
    endtask

    initial begin
        nop_d = mk_d(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        bub_e = mk_e(1'b1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        rst = 1'b1; f_D = mk_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h9, 64'h9);
        D_stall = 1'b0; D_bubble = 1'b0; E_bubble = 1'b0;
        clear_fwd();
        step(); step();
        exp_e(cyc, bub_e, "reset_E");
        exp_s(cyc, 8'hFF, "reset_src");

        // OPq r2,r3 with r2/r3 preloaded through W in the same edge D loads
        rst = 1'b0;
        W_dstE = 4'd2; W_valE = 64'd5; W_dstM = 4'd3; W_valM = 64'd7;
        exp_s(cyc + 1, 8'h23, "opq_src");
        issue(mk_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0),
              mk_e(1'b1, 4'h6, 4'h0, 64'h0, 64'd5, 64'd7, 4'h3, 4'hF, 4'h2, 4'h3), "opq_regfile");
        clear_fwd();
        f_D = nop_d; step();

        // all five sources name r3: execute wins
        issue(mk_d(1'b1, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0),
              mk_e(1'b1, 4'h6, 4'h0, 64'h0, 64'h10, 64'h10, 4'h3, 4'hF, 4'h3, 4'h3), "fwd_e_beats_m_w");
        f_D = nop_d;
        e_dstE = 4'd3; e_valE = 64'h10; M_dstE = 4'd3; M_valE = 64'h20; M_dstM = 4'd3; m_valM = 64'h21;
        W_dstE = 4'd3; W_valE = 64'h30; W_dstM = 4'd3; W_valM = 64'h31;
        step(); clear_fwd();

        // M memory value beats M ALU value (r5)
        issue(mk_d(1'b1, 4'h4, 4'h0, 4'h5, 4'h5, 64'h8, 64'h0),
              mk_e(1'b1, 4'h4, 4'h0, 64'h8, 64'hAA, 64'hAA, 4'hF, 4'hF, 4'h5, 4'h5), "fwd_mm_beats_me");
        f_D = nop_d;
        M_dstM = 4'd5; m_valM = 64'hAA; M_dstE = 4'd5; M_valE = 64'hBB;
        W_dstM = 4'd5; W_valM = 64'hCC; W_dstE = 4'd5; W_valE = 64'hDD;
        step(); clear_fwd();

        // M ALU value beats both W values
        issue(mk_d(1'b1, 4'h4, 4'h0, 4'h5, 4'h5, 64'h8, 64'h0),
              mk_e(1'b1, 4'h4, 4'h0, 64'h8, 64'hBB, 64'hBB, 4'hF, 4'hF, 4'h5, 4'h5), "fwd_me_beats_w");
        f_D = nop_d;
        M_dstE = 4'd5; M_valE = 64'hBB; W_dstM = 4'd5; W_valM = 64'h5A; W_dstE = 4'd5; W_valE = 64'h5B;
        step(); clear_fwd();

        // same-cycle regfile write: W memory value beats W ALU value
        issue(mk_d(1'b1, 4'h4, 4'h0, 4'h6, 4'h6, 64'h0, 64'h0),
              mk_e(1'b1, 4'h4, 4'h0, 64'h0, 64'h77, 64'h77, 4'hF, 4'hF, 4'h6, 4'h6), "fwd_wm_beats_we");
        f_D = nop_d;
        W_dstM = 4'd6; W_valM = 64'h77; W_dstE = 4'd6; W_valE = 64'h88;
        step(); clear_fwd();

        // both write ports hit r5; later read must see W_valM
        W_dstM = 4'd5; W_valM = 64'h55; W_dstE = 4'd5; W_valE = 64'h66;
        f_D = nop_d; step(); clear_fwd();
        issue(mk_d(1'b1, 4'h4, 4'h0, 4'h5, 4'h5, 64'h0, 64'h0),
              mk_e(1'b1, 4'h4, 4'h0, 64'h0, 64'h55, 64'h55, 4'hF, 4'hF, 4'h5, 4'h5), "rf_wm_wins_write");

        // back-to-back: call, jXX, pushq, cmovXX, invalid icode
        exp_s(cyc + 1, 8'hF4, "call_src");
        issue(mk_d(1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40),
              mk_e(1'b1, 4'h8, 4'h0, 64'h100, 64'h40, 64'h0, 4'h4, 4'hF, 4'hF, 4'h4), "call");
        issue(mk_d(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h50),
              mk_e(1'b1, 4'h7, 4'h3, 64'h200, 64'h50, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF), "jxx_valp");
        issue(mk_d(1'b1, 4'hA, 4'h0, 4'h6, 4'hF, 64'h0, 64'h0),
              mk_e(1'b1, 4'hA, 4'h0, 64'h0, 64'h77, 64'h0, 4'h4, 4'hF, 4'h6, 4'h4), "pushq");
        issue(mk_d(1'b1, 4'h2, 4'h1, 4'h2, 4'h9, 64'h0, 64'h0),
              mk_e(1'b1, 4'h2, 4'h1, 64'h0, 64'd5, 64'h0, 4'h9, 4'hF, 4'h2, 4'hF), "cmov");
        issue(mk_d(1'b0, 4'hC, 4'h0, 4'h2, 4'h3, 64'h11, 64'h22),
              mk_e(1'b0, 4'hC, 4'h0, 64'h11, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF), "bad_icode");

        // popq with %rsp forwarded from execute, then a nop that must ignore ID 15
        issue(mk_d(1'b1, 4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h0),
              mk_e(1'b1, 4'hB, 4'h0, 64'h0, 64'h1000, 64'h1000, 4'h4, 4'h7, 4'h4, 4'h4), "popq_fwd");
        e_dstE = 4'd4; e_valE = 64'h1000;
        issue(nop_d, bub_e, "rnone_no_fwd");
        clear_fwd();
        e_valE = 64'hDEAD; m_valM = 64'hBEEF; W_valM = 64'hCAFE;
        f_D = nop_d; step(); clear_fwd();

        // D_stall holds, stall beats bubble, then bubble, then E_bubble
        issue(mk_d(1'b1, 4'h3, 4'h0, 4'hF, 4'h9, 64'h99, 64'h0),
              mk_e(1'b1, 4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h9, 4'hF, 4'hF, 4'hF), "irmov");
        D_stall = 1'b1; f_D = mk_d(1'b1, 4'h6, 4'h0, 4'h1, 4'h1, 64'h0, 64'h0);
        exp_e(cyc + 1, mk_e(1'b1, 4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h9, 4'hF, 4'hF, 4'hF), "stall_hold1");
        step();
        f_D = mk_d(1'b1, 4'h6, 4'h1, 4'h2, 4'h2, 64'h0, 64'h0);
        exp_e(cyc + 1, mk_e(1'b1, 4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h9, 4'hF, 4'hF, 4'hF), "stall_hold2");
        step();
        D_bubble = 1'b1;
        exp_e(cyc + 1, mk_e(1'b1, 4'h3, 4'h0, 64'h99, 64'h0, 64'h0, 4'h9, 4'hF, 4'hF, 4'hF), "stall_beats_bubble");
        step();
        D_stall = 1'b0;
        exp_e(cyc + 2, bub_e, "d_bubble");
        step();
        D_bubble = 1'b0; f_D = mk_d(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
        step();
        E_bubble = 1'b1; f_D = nop_d;
        exp_e(cyc + 1, bub_e, "e_bubble");
        step();
        E_bubble = 1'b0;

        // reset with mrmovq in both D and E: flush both, clear all registers
        issue(mk_d(1'b1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h30, 64'h0),
              mk_e(1'b1, 4'h5, 4'h0, 64'h30, 64'h0, 64'd5, 4'hF, 4'h1, 4'hF, 4'h2), "mrmov_pre_rst");
        f_D = mk_d(1'b1, 4'h5, 4'h0, 4'h7, 4'h3, 64'h40, 64'h0);
        step();
        rst = 1'b1; f_D = nop_d;
        exp_e(cyc + 1, bub_e, "rst_flush_E");
        exp_s(cyc + 1, 8'hFF, "rst_flush_D");
        step();
        rst = 1'b0;
        exp_e(cyc + 1, bub_e, "rst_D_bubble");
        for (int i = 0; i < 15; i++) begin
            issue(mk_d(1'b1, 4'h4, 4'h0, 4'(i), 4'(i), 64'h0, 64'h0),
                  mk_e(1'b1, 4'h4, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'(i), 4'(i)),
                  $sformatf("rf_clear_r%0d", i));
        end
        f_D = nop_d;
        step(); step(); step();
        done = 1'b1;
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode stage; sits directly downstream of fetch and consumes its 145-bit D bundle.
- Holds the D pipeline register, the 15-entry register file (written from the W stage), and the srcA/srcB/dstE/dstM selection logic.
- Holds the five-source forwarding network and the E pipeline register feeding execute.

Parameters:
- XLEN, 64, data/address width.
- NREG, 15, architectural registers (IDs 0-14); ID 15 = RNONE.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- f_D  in  145  fetch bundle: [144] stat(1=AOK), [143:140] icode, [139:136] ifun, [135:132] rA, [131:128] rB, [127:64] valC, [63:0] valP.
- D_stall  in  1  hold the D register.
- D_bubble  in  1  load nop into the D register.
- E_bubble  in  1  load nop into the E register.
- e_dstE  in  4  execute destination.
- e_valE  in  64  execute result.
- M_dstE  in  4  memory-stage register destination.
- M_valE  in  64  memory-stage register value.
- M_dstM  in  4  memory-stage memory destination.
- m_valM  in  64  memory-stage memory value.
- W_dstE  in  4  write-back register destination; also the regfile write port E.
- W_valE  in  64  write-back register value.
- W_dstM  in  4  write-back memory destination; also the regfile write port M.
- W_valM  in  64  write-back memory value.
- d_srcA  out  4  combinational source A, for the hazard unit.
- d_srcB  out  4  combinational source B, for the hazard unit.
- E  out  217  registered bundle: [216] stat, [215:212] icode, [211:208] ifun, [207:144] valC, [143:80] valA, [79:16] valB, [15:12] dstE, [11:8] dstM, [7:4] srcA, [3:0] srcB.

Behaviour:
- Reset (rst=1 at a rising edge):
  - D register and E register load the bubble: stat=1, icode=1 (nop), ifun=0, rA/rB/dst/src=15, all values 0.
  - All 15 registers are cleared to 0.
  - rst overrides stall and bubble; a reset mid-stream discards both in-flight instructions.
- D register update, priority order:
  1. rst.
  2. D_stall: hold. D_stall wins over D_bubble when both are asserted.
  3. D_bubble: load the bubble.
  4. Otherwise load f_D.
- srcA selection (D fields):
  - icode in {2,4,6,10}: rA.
  - icode in {9,11}: 4 (%rsp).
  - else 15.
- srcB selection (D fields):
  - icode in {4,5,6}: rB.
  - icode in {8,9,10,11}: 4.
  - else 15.
- dstE selection:
  - icode 2: rB if cnd; cnd is not known here, so rB is always passed and execute squashes it.
  - icode in {3,6}: rB.
  - icode in {8,9,10,11}: 4.
  - else 15.
- dstM selection:
  - icode in {5,11}: rA.
  - else 15.
- Forwarded valA, first match wins:
  1. icode in {7,8}: valP.
  2. srcA==e_dstE: e_valE.
  3. srcA==M_dstM: m_valM.
  4. srcA==M_dstE: M_valE.
  5. srcA==W_dstM: W_valM.
  6. srcA==W_dstE: W_valE.
  7. Otherwise the regfile read.
  - A source or destination of 15 never matches.
  - valB uses the same chain without step 1.
- Register file:
  - Reads are combinational; reading ID 15 returns 0.
  - Writes occur on the rising edge: W_dstE<-W_valE, then W_dstM<-W_valM. When both target the same ID, W_valM wins.
  - A same-cycle read of a register being written returns the new value, via forwarding steps 5-6.
- E register update, priority order:
  1. rst.
  2. E_bubble: load the bubble.
  3. Otherwise load the decoded fields.
- Latency: one cycle from D register to E register.
- Stat passes through unchanged; an icode>11 arrives with stat=0 and is propagated without decode (all srcs/dsts 15).

Decomposition:
- Package y86_pkg holds:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=10, POP=11.
  - RSP=4, RNONE=15.
  - STAT_AOK=1.
  - D and E bundle bit offsets.
  - Bubble constants.
- One sub-module: regfile_15x64, with 2 combinational read ports and 2 write ports, synchronous reset.

Test Plan:
- Reset, then rst=0 with f_D an OPq rA=2 rB=3 and reg2=5, reg3=7 preloaded via W:
  - next edge: E.valA=5, E.valB=7, E.dstE=3, E.srcA=2, E.srcB=3.
- irmovq to r3 in execute (e_dstE=3, e_valE=0x10) while D holds OPq r3,r3:
  - E.valA=E.valB=0x10 (e beats M and W).
- Same-cycle collisions, reading r5:
  - M_dstM=5 (m_valM=0xAA) together with M_dstE=5 (M_valE=0xBB) -> valA=0xAA.
  - W_dstM=W_dstE=5 -> regfile r5=W_valM after the edge.
- call in D (valP=0x40) -> E.valA=0x40, E.srcB=4, E.dstE=4, E.dstM=15.
- D_stall for 2 cycles while f_D changes -> D held; D_stall and D_bubble together -> held (stall wins); E_bubble -> E.icode=1, all dst=15.
- rst pulsed while a valid mrmovq sits in D and E -> both become bubbles and reg0..reg14 read 0.
